// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// Latency: WIDTH busy cycles after the start edge, then a one-cycle done pulse.
// Backpressure: none; start is ignored while busy and accepted in IDLE or DONE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             Sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             V,
  output logic             busy,
  output logic             done
);

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operand shift registers; bit 0 is always the bit being processed.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  // Holds the WIDTH-1 low result bits collected so far; the MSB arrives last
  // and goes straight into Sum, so it never needs a slot here.
  logic [WIDTH-2:0] psum;
  logic [WIDTH-2:0] psum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_nxt;
  logic             last_bit;
  logic             accept;

  // The single full-adder cell and the control decodes derived from state.
  always_comb begin
    s_bit    = op_a[0] ^ op_b[0] ^ carry;
    c_nxt    = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    last_bit = (state == RUN) && (cnt == LAST_BIT);
    accept   = start && (state != RUN);
  end

  // Partial-sum shift: new bit enters at the top, older bits move down.
  always_comb begin
    psum_nxt = psum;
    psum_nxt[WIDTH-2] = s_bit;
    for (int i = 0; i < WIDTH - 2; i++) begin
      psum_nxt[i] = psum[i+1];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH cycles, DONE exactly one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        if (start) state_nxt = RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and per-bit datapath; subtraction is A + ~B + ~borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      op_a  <= A;
      op_b  <= Sub ? ~B : B;
      carry <= Sub ? ~Cin : Cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      psum  <= psum_nxt;
      carry <= c_nxt;
      cnt   <= cnt + 1'b1;
    end
  end

  // Visible result updates only on the final bit, so partial sums never leak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum  <= '0;
      Cout <= 1'b0;
      V    <= 1'b0;
    end else if (last_bit) begin
      Sum  <= {s_bit, psum};
      Cout <= c_nxt;
      V    <= carry ^ c_nxt;
    end
  end

  // Handshake flags decode the registered state only.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 arithmetic, handshake and reset
// cases, plus an exhaustive back-to-back sweep on a WIDTH=3 instance.
// Each comparison is an immediate assertion feeding one failure counter.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic [7:0] sum8;
  logic       cout8, v8, busy8, done8;

  logic       start3, sub3, cin3;
  logic [2:0] a3, b3;
  logic [2:0] sum3;
  logic       cout3, v3, busy3, done3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .Sub(sub8), .Cin(cin8),
    .A(a8), .B(b8), .Sum(sum8), .Cout(cout8), .V(v8), .busy(busy8), .done(done8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .Sub(sub3), .Cin(cin3),
    .A(a3), .B(b3), .Sum(sum3), .Cout(cout3), .V(v3), .busy(busy3), .done(done3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // busy and done must never be high together on either instance.
  always @(negedge clk) begin
    check("busy_done_exclusive", {30'd0, busy8 & done8, busy3 & done3}, 32'd0);
  end

  // One WIDTH=8 operation, entered just after a negedge. Operands are
  // scrambled after capture; optionally start is re-pulsed mid-RUN.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic sub,
                      input logic [7:0] exp_sum, input logic exp_cout, input logic exp_v,
                      input logic [7:0] prev_sum, input logic mid_start);
    int  busy_cnt;
    logic got_done;
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~cin; sub8 = ~sub;
    check({tag, "_busy_first"}, {31'd0, busy8}, 32'd1);
    check({tag, "_sum_hold"}, {24'd0, sum8}, {24'd0, prev_sum});
    busy_cnt = 1;
    got_done = 1'b0;
    for (int i = 1; i < 20 && !got_done; i++) begin
      @(negedge clk);
      if (done8) got_done = 1'b1;
      else if (busy8) busy_cnt++;
      if (!got_done) start8 = mid_start && (i == 3);
    end
    start8 = 1'b0;
    check({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
    check({tag, "_busy_cycles"}, busy_cnt, 32'd8);
    check({tag, "_sum"}, {24'd0, sum8}, {24'd0, exp_sum});
    check({tag, "_cout"}, {31'd0, cout8}, {31'd0, exp_cout});
    check({tag, "_v"}, {31'd0, v8}, {31'd0, exp_v});
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {30'd0, done8, busy8}, 32'd0);
    check({tag, "_sum_held"}, {24'd0, sum8}, {24'd0, exp_sum});
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int r, sa, sb, rs;
    logic [2:0] ea, eb;
    logic ec, es;
    logic [7:0] k8;

    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start3 = 1'b0; sub3 = 1'b0; cin3 = 1'b0; a3 = '0; b3 = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs8", {21'd0, sum8, cout8, v8, busy8, done8}, 32'd0);
    check("reset_outputs3", {26'd0, sum3, cout3, v3, busy3, done3}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {30'd0, busy8, done8}, 32'd0);

    // Add and subtract directed vectors.
    run8("add_ff_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    run8("add_7f_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8'h00, 1'b0);
    run8("sub_10_01",  8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 8'h80, 1'b0);
    run8("sub_00_01b", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h0F, 1'b0);
    run8("sub_80_01",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8'hFE, 1'b0);
    // Mid-RUN start pulse with different operands must be ignored.
    run8("mid_start",  8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 8'h7F, 1'b1);

    // Exhaustive WIDTH=3 sweep, start held high, back-to-back operations.
    for (int k = 0; k < 256; k++) begin
      k8 = k[7:0];
      ea = k8[2:0]; eb = k8[5:3]; ec = k8[6]; es = k8[7];
      a3 = ea; b3 = eb; cin3 = ec; sub3 = es; start3 = 1'b1;
      @(posedge clk);
      busy_cnt = 0;
      done_cnt = 0;
      for (int j = 1; j <= 4; j++) begin
        @(negedge clk);
        if (busy3) busy_cnt++;
        if (done3) done_cnt++;
      end
      r  = int'(ea) + (es ? (7 - int'(eb)) : int'(eb)) + (es ? (1 - int'(ec)) : int'(ec));
      sa = (ea >= 3'd4) ? int'(ea) - 8 : int'(ea);
      sb = (eb >= 3'd4) ? int'(eb) - 8 : int'(eb);
      rs = es ? (sa - sb - int'(ec)) : (sa + sb + int'(ec));
      check("w3_busy_cycles", busy_cnt, 32'd3);
      check("w3_done_pulses", done_cnt, 32'd1);
      check("w3_done_at_4", {31'd0, done3}, 32'd1);
      check("w3_cout_sum", {28'd0, cout3, sum3}, r & 15);
      check("w3_v", {31'd0, v3}, {31'd0, (rs > 3) || (rs < -4)});
    end
    start3 = 1'b0;
    @(negedge clk);
    check("w3_idle_after_sweep", {30'd0, busy3, done3}, 32'd0);

    // Reset in the middle of an operation.
    run8("pre_reset", 8'h1E, 8'h1E, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h46, 1'b0);
    a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {21'd0, sum8, cout8, v8, busy8, done8}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("no_done_in_reset", {30'd0, done8, busy8}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("no_done_after_reset", {30'd0, done8, busy8}, 32'd0);
    end
    run8("post_reset", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
